taxi_eth_loopback_swap: RTL and testbench
=========================================

TAXI_ETH_LOOPBACK_SWAP -- requirements
Module: taxi_eth_loopback_swap

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W  64  stream data width; legal values 8, 16, 32, 64.
  KEEP_W  DATA_W/8  byte-enable width.
  ID_W  8  tid width, passed through unchanged.
  USER_W  1  tuser width; bit 0 is the bad-frame flag.
  CNT_W  32  width of the statistics counters.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock.
  rst  in  1  reset; asynchronous, active-high.
  s_axis  taxi_axis_if sink  DATA_W/KEEP_W/ID_W/USER_W  ingress frames.
  m_axis  taxi_axis_if source  same widths  egress frames.
  cfg_mode  in  2  0 = pass, 1 = swap MAC addresses, 2 = drop, 3 = drop.
  stat_frames  out  CNT_W  count of frames emitted.
  stat_dropped  out  CNT_W  count of frames discarded.
  stat_runt  out  CNT_W  count of frames with tlast before byte 12.
REQ-003 One clock and one reset SHALL be used; reset SHALL be asynchronous and active-high.

Function
REQ-004 cfg_mode SHALL be sampled on the first beat of each frame and held for the whole frame.
REQ-005 Define HDR_BEATS = ceil(12/KEEP_W); the header beat count is 12, 6, 3 or 2 for widths 8, 16, 32, 64.
REQ-006 The FSM SHALL have states IDLE, HDR, EMIT, PASS and DROP.
REQ-007 IDLE SHALL move to PASS in mode 0, to HDR in mode 1, and to DROP in modes 2 and 3, on the first accepted beat.
REQ-008 In HDR, beats SHALL be accepted into a HDR_BEATS x DATA_W buffer with no output until the buffer is full or tlast is seen.
REQ-009 When the buffer is full, bytes 0-5 and 6-11 SHALL be exchanged, and the state SHALL move to EMIT.
REQ-010 In EMIT, the buffered beats SHALL be output in order with s_tready low; the state SHALL then move to PASS, or to IDLE if the last buffered beat carried tlast.
REQ-011 If tlast arrives in HDR before 12 bytes are accepted, the buffered beats SHALL be emitted unmodified in EMIT and stat_runt SHALL increment.
REQ-012 Bytes 12 onward, tkeep, tid and tuser SHALL pass through unmodified.
REQ-013 PASS SHALL forward beats through a single output register with 1-cycle latency and full throughput; s_tready SHALL equal !m_tvalid_reg || m_tready.
REQ-014 DROP SHALL hold s_tready high, output nothing, and return to IDLE after tlast.
REQ-015 stat_frames SHALL increment when a tlast beat is accepted on m_axis.
REQ-016 stat_dropped SHALL increment when a tlast beat is accepted in DROP.
REQ-017 All counters SHALL wrap modulo 2^CNT_W without saturating.
REQ-018 If several counters increment in the same cycle, each SHALL increment independently.
REQ-019 m_tvalid SHALL not deassert and m_axis payload SHALL not change while m_tvalid is high and m_tready is low.
REQ-020 A cfg_mode change mid-frame SHALL have no effect until the next frame.
REQ-021 A frame whose last beat carries tuser[0]=1 SHALL still be forwarded; filtering bad frames is the downstream FIFO's job.

Reset
REQ-022 On rst, the FSM SHALL enter IDLE; m_tvalid, s_tready and all stat_* outputs SHALL be 0, and the header buffer contents SHALL be don't-care.
REQ-023 Asserting rst mid-frame SHALL abandon the frame; after release, the next accepted beat SHALL be treated as a first beat.
REQ-024 s_tready SHALL rise one cycle after rst deasserts.

Structure
REQ-025 Package taxi_eth_loopback_pkg SHALL hold the mode_t enum (PASS, SWAP, DROP) and the state_t enum.
REQ-026 HDR_BEATS and the byte offsets 6 and 12 SHALL be localparams in the module.
REQ-027 No sub-module SHALL be used; the output register is inline, since header buffering makes a generic register slice unsuitable.

Verification
REQ-028 DATA_W=64, mode 1, 64-byte frame with dst 02:00:00:00:00:01 and src 02:00:00:00:00:02 -> output dst/src exchanged, bytes 12-63 identical, stat_frames=1.
REQ-029 DATA_W=8, mode 1, 8-byte runt frame -> output identical to input, stat_runt=1, stat_frames=1.
REQ-030 DATA_W=64, mode 0, 100 back-to-back 64-byte frames with m_tready always high -> one output beat per cycle after 1-cycle latency, stat_frames=100.
REQ-031 Mode 2, 3 frames -> m_tvalid never high, stat_dropped=3; switch to mode 0 mid-frame -> that frame is still dropped.
REQ-032 Mode 1, random m_tready at 50% -> output data stable while stalled, payload matches the scoreboard.
REQ-033 rst pulse during EMIT -> m_tvalid=0 and counters=0 the next cycle; a following 64-byte swap frame is output correctly.

Source files
------------

// File: rtl/taxi_eth_loopback_pkg.sv
// Shared types for the Ethernet loopback / MAC-swap block.
// cfg_mode codes 2 and 3 both discard the frame.
package taxi_eth_loopback_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_SWAP = 2'd1,
    MODE_DROP = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_EMIT,
    ST_PASS,
    ST_DROP
  } state_t;

  function automatic mode_t decode_mode(input logic [1:0] m);
    if (m == 2'd0) return MODE_PASS;
    if (m == 2'd1) return MODE_SWAP;
    return MODE_DROP;
  endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream bundle with source and sink views.
// tready flows sink to source; everything else source to sink.
interface taxi_axis_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8,
  parameter int ID_W = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;

  modport src (
    output tdata, tkeep, tvalid, tlast, tid, tuser,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tvalid, tlast, tid, tuser,
    output tready
  );
endinterface

// File: rtl/taxi_eth_loopback_swap.sv
// Ethernet loopback with optional dst/src MAC exchange.
// Header beats are buffered so both addresses are known before emission.
module taxi_eth_loopback_swap
  import taxi_eth_loopback_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8,
  parameter int ID_W = 8,
  parameter int USER_W = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  taxi_axis_if.snk         s_axis,
  taxi_axis_if.src         m_axis,
  input  logic [1:0]       cfg_mode,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_dropped,
  output logic [CNT_W-1:0] stat_runt
);

  localparam int HDR_BYTES = 12;
  localparam int SRC_OFS = 6;
  localparam int HDR_BEATS = (HDR_BYTES + KEEP_W - 1) / KEEP_W;
  localparam int IDX_W = $clog2(HDR_BEATS);
  localparam int BUF_W = HDR_BEATS * DATA_W;

  state_t state, state_nxt;
  logic   run;

  logic [DATA_W-1:0] hdr_data [HDR_BEATS];
  logic [KEEP_W-1:0] hdr_keep [HDR_BEATS];
  logic [ID_W-1:0]   hdr_id   [HDR_BEATS];
  logic [USER_W-1:0] hdr_user [HDR_BEATS];
  logic [IDX_W-1:0]  wr_idx, rd_idx, buf_end;
  logic              buf_last, buf_swap;

  logic              o_valid, o_last;
  logic [DATA_W-1:0] o_data;
  logic [KEEP_W-1:0] o_keep;
  logic [ID_W-1:0]   o_id;
  logic [USER_W-1:0] o_user;

  logic             s_ready, s_fire, out_ready;
  logic             ld, ld_buf, buf_wr;
  logic             runt_inc, drop_inc;
  logic [IDX_W-1:0] cur_idx;
  logic [7:0]       hdr_bytes;
  logic             hdr_short, hdr_end;
  logic [BUF_W-1:0] hdr_flat, hdr_swap;
  logic [DATA_W-1:0] emit_data;

  assign s_fire    = s_axis.tvalid && s_ready;
  assign out_ready = !o_valid || m_axis.tready;
  assign cur_idx   = (state == ST_IDLE) ? '0 : wr_idx;
  assign hdr_bytes = 8'(cur_idx) * 8'(KEEP_W)
                   + 8'($countones(s_axis.tkeep));
  assign hdr_short = hdr_bytes < 8'(HDR_BYTES);
  assign hdr_end   = s_axis.tlast ||
                     (cur_idx == IDX_W'(HDR_BEATS - 1));

  always_comb begin
    hdr_flat = '0;
    for (int b = 0; b < HDR_BEATS; b++)
      hdr_flat[b*DATA_W +: DATA_W] = hdr_data[b];
    hdr_swap = hdr_flat;
    if (buf_swap) begin
      for (int i = 0; i < SRC_OFS; i++) begin
        hdr_swap[8*i +: 8] = hdr_flat[8*(i+SRC_OFS) +: 8];
        hdr_swap[8*(i+SRC_OFS) +: 8] = hdr_flat[8*i +: 8];
      end
    end
    emit_data = hdr_swap[int'(rd_idx)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    ld        = 1'b0;
    ld_buf    = 1'b0;
    buf_wr    = 1'b0;
    runt_inc  = 1'b0;
    drop_inc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        s_ready = run && out_ready;
        if (s_fire) begin
          unique case (decode_mode(cfg_mode))
            MODE_PASS: begin
              ld = 1'b1;
              state_nxt = s_axis.tlast ? ST_IDLE : ST_PASS;
            end
            MODE_SWAP: begin
              buf_wr = 1'b1;
              runt_inc = s_axis.tlast && hdr_short;
              state_nxt = hdr_end ? ST_EMIT : ST_HDR;
            end
            MODE_DROP: begin
              drop_inc = s_axis.tlast;
              state_nxt = s_axis.tlast ? ST_IDLE : ST_DROP;
            end
            default: ;
          endcase
        end
      end
      ST_HDR: begin
        s_ready = run;
        if (s_fire) begin
          buf_wr = 1'b1;
          runt_inc = s_axis.tlast && hdr_short;
          if (hdr_end) state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          ld = 1'b1;
          ld_buf = 1'b1;
          if (rd_idx == buf_end)
            state_nxt = buf_last ? ST_IDLE : ST_PASS;
        end
      end
      ST_PASS: begin
        s_ready = run && out_ready;
        if (s_fire) begin
          ld = 1'b1;
          if (s_axis.tlast) state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        s_ready = run;
        if (s_fire && s_axis.tlast) begin
          drop_inc = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Header storage needs no reset; control below qualifies it
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      hdr_data[cur_idx] <= s_axis.tdata;
      hdr_keep[cur_idx] <= s_axis.tkeep;
      hdr_id[cur_idx]   <= s_axis.tid;
      hdr_user[cur_idx] <= s_axis.tuser;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      buf_end  <= '0;
      buf_last <= 1'b0;
      buf_swap <= 1'b0;
    end else begin
      if (buf_wr) begin
        if (hdr_end) begin
          wr_idx   <= '0;
          rd_idx   <= '0;
          buf_end  <= cur_idx;
          buf_last <= s_axis.tlast;
          buf_swap <= !(s_axis.tlast && hdr_short);
        end else begin
          wr_idx <= cur_idx + 1'b1;
        end
      end
      if (ld_buf) rd_idx <= rd_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
      o_id    <= '0;
      o_user  <= '0;
    end else if (ld) begin
      o_valid <= 1'b1;
      if (ld_buf) begin
        o_data <= emit_data;
        o_keep <= hdr_keep[rd_idx];
        o_last <= buf_last && (rd_idx == buf_end);
        o_id   <= hdr_id[rd_idx];
        o_user <= hdr_user[rd_idx];
      end else begin
        o_data <= s_axis.tdata;
        o_keep <= s_axis.tkeep;
        o_last <= s_axis.tlast;
        o_id   <= s_axis.tid;
        o_user <= s_axis.tuser;
      end
    end else if (m_axis.tready) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames  <= '0;
      stat_dropped <= '0;
      stat_runt    <= '0;
    end else begin
      if (o_valid && m_axis.tready && o_last)
        stat_frames <= stat_frames + 1'b1;
      if (drop_inc)
        stat_dropped <= stat_dropped + 1'b1;
      if (runt_inc)
        stat_runt <= stat_runt + 1'b1;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = o_valid;
  assign m_axis.tdata  = o_data;
  assign m_axis.tkeep  = o_keep;
  assign m_axis.tlast  = o_last;
  assign m_axis.tid    = o_id;
  assign m_axis.tuser  = o_user;

endmodule

// File: tb/tb_taxi_eth_loopback_swap.sv
// Bench for taxi_eth_loopback_swap: byte-level frame model,
// vector table, random frames and reset/throughput sequences.
module tb_taxi_eth_loopback_swap;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 8;
  localparam int UW = 1;
  localparam int CW = 32;
  localparam int NV = 15;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
  } beat_t;

  typedef struct {
    int mode;
    int len;
    int mid_mode;
    bit user;
    bit mac;
    int rdy;
    int d_fr;
    int d_dr;
    int d_ru;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic [CW-1:0] stat_frames, stat_dropped, stat_runt;

  taxi_axis_if #(.DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .USER_W(UW)) s_if ();
  taxi_axis_if #(.DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .USER_W(UW)) m_if ();

  taxi_eth_loopback_swap #(
    .DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .USER_W(UW), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .cfg_mode(cfg_mode),
    .stat_frames(stat_frames),
    .stat_dropped(stat_dropped),
    .stat_runt(stat_runt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rdy_mode = 1;
  bit gaps = 0;
  int exp_fr = 0, exp_dr = 0, exp_ru = 0;
  beat_t exp_q[$];
  vec_t vt[NV];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_if.tready = 1'b0;
      1: m_if.tready = 1'b1;
      default: m_if.tready = 1'($urandom_range(1));
    endcase
  end

  task automatic chk(input bit ok, input string name,
                     input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Output monitor: scoreboard compare and stall stability
  beat_t prev, cur, e;
  bit prev_stall = 0;
  bit arm = 0;
  int first_in = 0, last_in = 0, last_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      cur.data = m_if.tdata;
      cur.keep = m_if.tkeep;
      cur.last = m_if.tlast;
      cur.id   = m_if.tid;
      cur.user = m_if.tuser;
      if (prev_stall)
        chk(m_if.tvalid && cur == prev, "stall_hold", cur, prev);
      if (s_if.tvalid && s_if.tready) begin
        last_in = cyc;
        if (arm) begin
          first_in = cyc;
          arm = 0;
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        last_out = cyc;
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_beat", cur, 0);
        end else begin
          e = exp_q.pop_front();
          chk(cur == e, "out_beat", cur, e);
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev = cur;
    end
  end

  function automatic beat_t mk_beat(input byte unsigned a[$], input int bi,
                                    input logic [IW-1:0] id, input bit user);
    beat_t b;
    int nb;
    nb = (a.size() + KW - 1) / KW;
    b = '0;
    for (int k = 0; k < KW; k++) begin
      if (bi*KW + k < a.size()) begin
        b.data[8*k +: 8] = a[bi*KW + k];
        b.keep[k] = 1'b1;
      end
    end
    b.last = (bi == nb - 1);
    b.id = id;
    b.user = UW'(b.last && user);
    return b;
  endfunction

  task automatic put_beat(input beat_t b);
    int n;
    n = 0;
    while (gaps && $urandom_range(3) == 0) begin
      s_if.tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.data;
    s_if.tkeep  = b.keep;
    s_if.tlast  = b.last;
    s_if.tid    = b.id;
    s_if.tuser  = b.user;
    do begin
      @(negedge clk);
      n++;
    end while (!s_if.tready && n < 2000);
    if (!s_if.tready) chk(0, "in_timeout", 0, 1);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    byte unsigned fr[$];
    byte unsigned ex[$];
    byte unsigned mac[12];
    logic [IW-1:0] id;
    int nb;
    mac = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    id = IW'($urandom);
    for (int i = 0; i < v.len; i++)
      fr.push_back(v.mac ? 8'(i) : 8'($urandom));
    if (v.mac)
      for (int i = 0; i < 12; i++) fr[i] = mac[i];
    ex = fr;
    if (v.mode == 1 && v.len >= 12) begin
      for (int i = 0; i < 6; i++) begin
        ex[i] = fr[i+6];
        ex[i+6] = fr[i];
      end
    end
    nb = (v.len + KW - 1) / KW;
    if (v.mode < 2)
      for (int b = 0; b < nb; b++) exp_q.push_back(mk_beat(ex, b, id, v.user));
    cfg_mode = 2'(v.mode);
    for (int b = 0; b < nb; b++) begin
      put_beat(mk_beat(fr, b, id, v.user));
      if (b == 0 && v.mid_mode >= 0) cfg_mode = 2'(v.mid_mode);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(exp_q.size() == 0 && !m_if.tvalid, name, 96'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
    chk(stat_frames == CW'(exp_fr), {tag, "_frames"}, stat_frames, exp_fr);
    chk(stat_dropped == CW'(exp_dr), {tag, "_dropped"}, stat_dropped, exp_dr);
    chk(stat_runt == CW'(exp_ru), {tag, "_runt"}, stat_runt, exp_ru);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    beat_t b0, b1;
    byte unsigned fr[$];
    int m;
    vt[0]  = '{1, 64, -1, 0, 1, 1, 1, 0, 0};
    vt[1]  = '{1,  8, -1, 0, 0, 1, 1, 0, 1};
    vt[2]  = '{0, 64, -1, 0, 0, 1, 1, 0, 0};
    vt[3]  = '{2, 64, -1, 0, 0, 1, 0, 1, 0};
    vt[4]  = '{3, 20, -1, 0, 0, 1, 0, 1, 0};
    vt[5]  = '{1, 12, -1, 0, 0, 1, 1, 0, 0};
    vt[6]  = '{1, 11, -1, 0, 0, 1, 1, 0, 1};
    vt[7]  = '{1, 16, -1, 1, 0, 1, 1, 0, 0};
    vt[8]  = '{0,  1, -1, 0, 0, 1, 1, 0, 0};
    vt[9]  = '{2,  1, -1, 0, 0, 1, 0, 1, 0};
    vt[10] = '{2, 40,  0, 0, 0, 1, 0, 1, 0};
    vt[11] = '{1, 30,  2, 0, 0, 2, 1, 0, 0};
    vt[12] = '{1,100, -1, 1, 0, 2, 1, 0, 0};
    vt[13] = '{0, 65,  3, 0, 0, 2, 1, 0, 0};
    vt[14] = '{1,  9, -1, 0, 0, 2, 1, 0, 1};

    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tlast = 1'b0;
    s_if.tid = '0;
    s_if.tuser = '0;
    m_if.tready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk(!m_if.tvalid, "rst_tvalid", m_if.tvalid, 0);
    chk(!s_if.tready, "rst_tready", s_if.tready, 0);
    chk_stats("rst");
    rst = 1'b0;
    #1;
    chk(!s_if.tready, "release_tready", s_if.tready, 0);
    @(posedge clk); #1;
    chk(s_if.tready, "run_tready", s_if.tready, 1);

    for (int i = 0; i < NV; i++) begin
      rdy_mode = vt[i].rdy;
      gaps = (vt[i].rdy == 2);
      send_frame(vt[i]);
      drain($sformatf("v%0d_drain", i));
      exp_fr += vt[i].d_fr;
      exp_dr += vt[i].d_dr;
      exp_ru += vt[i].d_ru;
      chk_stats($sformatf("v%0d", i));
    end

    // Full-throughput pass-through burst
    rdy_mode = 1;
    gaps = 0;
    repeat (2) @(posedge clk);
    #1;
    arm = 1;
    v = '{0, 64, -1, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 100; i++) send_frame(v);
    drain("burst_drain");
    exp_fr += 100;
    chk(last_in - first_in == 799, "burst_in_rate", last_in - first_in, 799);
    chk(last_out - first_in == 800, "burst_latency", last_out - first_in, 800);
    chk_stats("burst");

    // Random frames under random backpressure and input gaps
    rdy_mode = 2;
    gaps = 1;
    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(3);
      v = '{m, $urandom_range(80, 1), $urandom_range(4) - 1,
            1'($urandom_range(1)), 0, 2, 0, 0, 0};
      if (m < 2) exp_fr++;
      else exp_dr++;
      if (m == 1 && v.len < 12) exp_ru++;
      send_frame(v);
    end
    drain("rand_drain");
    chk_stats("rand");

    // Reset while a swapped header is stuck in EMIT
    gaps = 0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) fr.push_back(8'($urandom));
    b0 = mk_beat(fr, 0, 8'h5a, 0);
    b1 = mk_beat(fr, 1, 8'h5a, 0);
    cfg_mode = 2'd1;
    put_beat(b0);
    put_beat(b1);
    repeat (3) @(posedge clk);
    #1;
    chk(m_if.tvalid, "emit_tvalid", m_if.tvalid, 1);
    chk(!s_if.tready, "emit_tready", s_if.tready, 0);
    #2 rst = 1'b1;
    #1;
    chk(!m_if.tvalid, "mid_rst_tvalid", m_if.tvalid, 0);
    chk(!s_if.tready, "mid_rst_tready", s_if.tready, 0);
    exp_fr = 0;
    exp_dr = 0;
    exp_ru = 0;
    chk_stats("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk(!s_if.tready, "rerelease_tready", s_if.tready, 0);
    @(posedge clk); #1;
    chk(s_if.tready, "rerun_tready", s_if.tready, 1);
    rdy_mode = 1;
    v = '{1, 64, -1, 0, 1, 1, 0, 0, 0};
    send_frame(v);
    drain("post_rst_drain");
    exp_fr = 1;
    chk_stats("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
